// File: rtl/rv32i_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : rv32i_pkg                                                  |
// | Description : Shared RV32I decode constants, encodings and the ID/EX      |
// |               pipeline register layout.                                  |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    result_src_e       result_src;
    alu_ctrl_e         alu_ctrl;
    logic [2:0]        funct3;
    logic              illegal;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } idex_t;

  // ALU operation for R/I arithmetic. sltu shares the slt encoding and sra
  // shares srl, since the ALU offers no separate unsigned/arithmetic ops.
  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:         return sub ? ALU_SUB : ALU_ADD;
      3'b001:         return ALU_SLL;
      3'b010, 3'b011: return ALU_SLT;
      3'b100:         return ALU_XOR;
      3'b101:         return ALU_SRL;
      3'b110:         return ALU_OR;
      default:        return ALU_AND;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : register_file                                              |
// | Description : 2-read / 1-write architectural register file; x0 is        |
// |               hard-wired to zero. Optional write-through bypass on the   |
// |               read ports when WB_BYPASS_EN is defined.                   |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
module register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_ra1,
  input  logic [ADDR_W-1:0] i_ra2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_hit1;
  logic              w_hit2;

  // Storage: clear on reset, otherwise single write port that ignores x0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

`ifdef WB_BYPASS_EN
  // Same-cycle writeback is forwarded straight to a matching read port.
  assign w_hit1 = i_we && (i_ra1 == i_wa);
  assign w_hit2 = i_we && (i_ra2 == i_wa);
`else
  // Collision returns the stored (old) value; the hazard unit handles it.
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  // x0 check comes first so a bypass hit on index 0 can never leak data.
  assign o_rd1 = (i_ra1 == '0) ? '0 : (w_hit1 ? i_wd : r_regs[i_ra1]);
  assign o_rd2 = (i_ra2 == '0) ? '0 : (w_hit2 ? i_wd : r_regs[i_ra2]);

endmodule
`default_nettype wire

// File: rtl/decode_cycle.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : decode_cycle                                               |
// | Description : RV32I decode stage: register file, control decoder,       |
// |               immediate generator and ID/EX pipeline register.          |
// |               Define WB_BYPASS_EN for writeback-to-read forwarding.     |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
module decode_cycle
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic [REG_AW-1:0] Rs1D,
  output logic [REG_AW-1:0] Rs2D,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [2:0]        Funct3E,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] RdE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic              IllegalE
);

  logic [6:0]      w_opcode;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [XLEN-1:0] w_imm;
  imm_src_e        w_imm_src;
  idex_t           w_idex;
  idex_t           r_idex;

  assign w_opcode = InstrD[6:0];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];

  register_file #(
    .DATA_W   (XLEN),
    .ADDR_W   (REG_AW),
    .NUM_REGS (REG_COUNT)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (Rs1D),
    .i_ra2 (Rs2D),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (RegWriteW),
    .i_wa  (RdW),
    .i_wd  (ResultW)
  );

  // Main/ALU control decode and assembly of the next ID/EX contents.
  always_comb begin
    w_idex          = '0;
    w_imm_src       = IMM_I;
    w_idex.funct3   = InstrD[14:12];
    w_idex.rd1      = w_rd1;
    w_idex.rd2      = w_rd2;
    w_idex.pc       = PCD;
    w_idex.pc4      = PCPlus4D;
    w_idex.rd       = InstrD[11:7];
    w_idex.rs1      = Rs1D;
    w_idex.rs2      = Rs2D;
    case (w_opcode)
      c_op_load: begin
        w_idex.reg_write  = 1'b1;
        w_idex.alu_src    = 1'b1;
        w_idex.result_src = RES_MEM;
      end
      c_op_store: begin
        w_idex.mem_write = 1'b1;
        w_idex.alu_src   = 1'b1;
        w_imm_src        = IMM_S;
      end
      c_op_rtype: begin
        w_idex.reg_write = 1'b1;
        w_idex.alu_ctrl  = alu_from_funct3(InstrD[14:12], InstrD[30]);
      end
      c_op_itype: begin
        w_idex.reg_write = 1'b1;
        w_idex.alu_src   = 1'b1;
        w_idex.alu_ctrl  = alu_from_funct3(InstrD[14:12], 1'b0);
      end
      c_op_branch: begin
        w_idex.branch   = 1'b1;
        w_idex.alu_ctrl = ALU_SUB;
        w_imm_src       = IMM_B;
      end
      c_op_jal: begin
        w_idex.jump       = 1'b1;
        w_idex.reg_write  = 1'b1;
        w_idex.result_src = RES_PC4;
        w_imm_src         = IMM_J;
      end
      c_op_lui: begin
        w_idex.reg_write  = 1'b1;
        w_idex.alu_src    = 1'b1;
        w_idex.result_src = RES_IMM;
        w_imm_src         = IMM_U;
      end
      default: begin
        w_idex.illegal = 1'b1;
      end
    endcase
    w_idex.imm = w_imm;
  end

  // Immediate generator, sign-extended from InstrD[31].
  always_comb begin
    w_imm = {{20{InstrD[31]}}, InstrD[31:20]};
    case (w_imm_src)
      IMM_S:   w_imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   w_imm = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                        InstrD[11:8], 1'b0};
      IMM_J:   w_imm = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                        InstrD[30:21], 1'b0};
      IMM_U:   w_imm = {InstrD[31:12], 12'b0};
      default: w_imm = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  // ID/EX register: loads every cycle; reset or flush inserts a zero bubble.
  always_ff @(posedge clk) begin
    if (!rst || FlushE) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_idex;
    end
  end

  assign RegWriteE   = r_idex.reg_write;
  assign MemWriteE   = r_idex.mem_write;
  assign JumpE       = r_idex.jump;
  assign BranchE     = r_idex.branch;
  assign ALUSrcE     = r_idex.alu_src;
  assign ResultSrcE  = r_idex.result_src;
  assign ALUControlE = r_idex.alu_ctrl;
  assign Funct3E     = r_idex.funct3;
  assign IllegalE    = r_idex.illegal;
  assign RD1E        = r_idex.rd1;
  assign RD2E        = r_idex.rd2;
  assign ImmExtE     = r_idex.imm;
  assign PCE         = r_idex.pc;
  assign PCPlus4E    = r_idex.pc4;
  assign RdE         = r_idex.rd;
  assign Rs1E        = r_idex.rs1;
  assign Rs2E        = r_idex.rs2;

endmodule
`default_nettype wire

// File: tb/tb_decode_cycle.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : tb_decode_cycle                                            |
// | Description : Self-checking bench for decode_cycle with a reference      |
// |               model of the decode rules and the register file.           |
// |               Honours WB_BYPASS_EN when defined.                         |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
module tb_decode_cycle;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE, Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .IllegalE(IllegalE)
  );

  typedef struct packed {
    logic        rw, mw, j, b, as;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic [2:0]  f3;
    logic        ill;
    logic        imm_v;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
  } exp_t;

  int          n_checks;
  int          n_fail;
  logic [31:0] ref_regs [32];
  exp_t        exp_e;

  wire [13:0] dut_ctrl = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
                          ResultSrcE, ALUControlE, Funct3E, IllegalE};
  wire [14:0] dut_idx  = {RdE, Rs1E, Rs2E};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Register value seen by the decoder this cycle.
  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (we && wa == idx) return wd;
`endif
    return ref_regs[idx];
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << bits;
    return v[bits-1] ? (v | m) : (v & ~m);
  endfunction

  // Expected E-stage contents for the given D-stage inputs.
  function automatic exp_t predict(input logic r, input logic [31:0] ins, pc, pc4,
                                   input logic fl, we, input logic [4:0] wa,
                                   input logic [31:0] wd);
    exp_t e;
    logic [2:0] f3map [8];
    logic [31:0] u;
    f3map = '{3'd0, 3'd6, 3'd5, 3'd5, 3'd4, 3'd7, 3'd3, 3'd2};
    e = '0;
    u = ins;
    if (!r || fl) begin
      e.imm_v = 1'b1;
      return e;
    end
    e.f3  = ins[14:12];
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.pc  = pc;
    e.pc4 = pc4;
    e.rd1 = ref_read(ins[19:15], we, wa, wd);
    e.rd2 = ref_read(ins[24:20], we, wa, wd);
    e.imm_v = 1'b1;
    case (ins[6:0])
      7'h03: begin e.rw = 1; e.rs = 2'd1; e.as = 1; e.imm = sext(u >> 20, 12); end
      7'h23: begin
        e.mw = 1; e.as = 1;
        e.imm = sext(((u >> 25) << 5) | ((u >> 7) & 32'h1F), 12);
      end
      7'h33: begin
        e.rw = 1; e.imm_v = 0;
        e.alu = (ins[14:12] == 3'd0 && ins[30]) ? 3'd1 : f3map[ins[14:12]];
      end
      7'h13: begin e.rw = 1; e.as = 1; e.alu = f3map[ins[14:12]]; e.imm = sext(u >> 20, 12); end
      7'h63: begin
        e.b = 1; e.alu = 3'd1;
        e.imm = sext(((u >> 31) << 12) | (((u >> 7) & 1) << 11) |
                     (((u >> 25) & 32'h3F) << 5) | (((u >> 8) & 32'hF) << 1), 13);
      end
      7'h6F: begin
        e.j = 1; e.rw = 1; e.rs = 2'd2;
        e.imm = sext(((u >> 31) << 20) | (((u >> 12) & 32'hFF) << 12) |
                     (((u >> 20) & 1) << 11) | (((u >> 21) & 32'h3FF) << 1), 21);
      end
      7'h37: begin e.rw = 1; e.rs = 2'd3; e.as = 1; e.imm = u & 32'hFFFF_F000; end
      default: begin e.ill = 1; e.imm_v = 0; end
    endcase
    return e;
  endfunction

  task automatic set_in(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4; FlushE = fl;
    RegWriteW = we; RdW = wa; ResultW = wd;
  endtask

  // One clock: record expectation, advance, update the model register file.
  task automatic cycle();
    exp_e = predict(rst, InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    end else if (RegWriteW && RdW != 5'd0) begin
      ref_regs[RdW] = ResultW;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      set_in(32'h0000_0013, 32'h0, 1'b0, 1'b1, 5'(i), 32'h0101_0101 * 32'(i));
      cycle();
    end
    rst = 1'b0;
    set_in(32'h0050_0093, 32'h40, 1'b0, 1'b1, 5'd2, 32'hFFFF);
    cycle();
    cycle();
    n_checks++;
    if ({dut_ctrl, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, dut_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctrl=%h imm=%h pc=%h idx=%h, expected all zero",
               dut_ctrl, ImmExtE, PCE, dut_idx);
    end
    n_checks++;
    if (IllegalE !== 1'b0) begin
      n_fail++; $display("FAIL reset_illegal: got %b expected 0", IllegalE);
    end
    rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      set_in((32'(i) << 20) | (32'(i) << 15) | 32'h33, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      cycle();
      n_checks++;
      if (RD1E !== 32'd0 || RD2E !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg x%0d: got rd1=%h rd2=%h expected 0", i, RD1E, RD2E);
      end
    end
  endtask

  task automatic test_addi();
    set_in(32'h0050_0093, 32'h10, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    n_checks++;
    if (dut_ctrl !== {5'b10001, 2'b00, 3'b000, 3'b000, 1'b0}) begin
      n_fail++; $display("FAIL addi_ctrl: got %b expected %b", dut_ctrl,
                         {5'b10001, 2'b00, 3'b000, 3'b000, 1'b0});
    end
    n_checks++;
    if (ImmExtE !== 32'd5 || RdE !== 5'd1 || PCE !== 32'h10 || PCPlus4E !== 32'h14) begin
      n_fail++;
      $display("FAIL addi_data: got imm=%h rd=%0d pc=%h pc4=%h expected 5/1/10/14",
               ImmExtE, RdE, PCE, PCPlus4E);
    end
  endtask

  task automatic test_writeback_read();
    set_in(32'h0000_0013, 32'h20, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    cycle();
    set_in(32'h0001_8233, 32'h24, 1'b0, 1'b1, 5'd0, 32'h1234_5678);
    cycle();
    n_checks++;
    if (RD1E !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wb_read_x3: got %h expected deadbeef", RD1E);
    end
    set_in(32'h0000_0233, 32'h28, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    n_checks++;
    if (RD1E !== 32'd0) begin
      n_fail++; $display("FAIL x0_write_ignored: got %h expected 0", RD1E);
    end
  endtask

  task automatic test_branch();
    set_in(32'hFE20_8CE3, 32'h30, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    n_checks++;
    if (BranchE !== 1'b1 || ALUControlE !== 3'b001 || Funct3E !== 3'b000 ||
        ImmExtE !== 32'hFFFF_FFF8 || RegWriteE !== 1'b0) begin
      n_fail++;
      $display("FAIL beq: got br=%b alu=%b f3=%b imm=%h rw=%b expected 1/001/000/fffffff8/0",
               BranchE, ALUControlE, Funct3E, ImmExtE, RegWriteE);
    end
  endtask

  task automatic test_flush();
    set_in(32'h0020_A423, 32'h34, 1'b1, 1'b1, 5'd5, 32'h0000_1234);
    cycle();
    n_checks++;
    if ({dut_ctrl, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, dut_idx} !== '0) begin
      n_fail++;
      $display("FAIL flush_bubble: got ctrl=%h imm=%h pc=%h idx=%h expected all zero",
               dut_ctrl, ImmExtE, PCE, dut_idx);
    end
    set_in(32'h0002_8433, 32'h38, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    n_checks++;
    if (RD1E !== 32'h0000_1234) begin
      n_fail++; $display("FAIL flush_wb_lands: got %h expected 00001234", RD1E);
    end
  endtask

  task automatic test_collision();
    logic [31:0] want;
    set_in(32'h0000_0013, 32'h40, 1'b0, 1'b1, 5'd6, 32'h11);
    cycle();
    set_in(32'h0003_03B3, 32'h44, 1'b0, 1'b1, 5'd6, 32'h55);
    cycle();
`ifdef WB_BYPASS_EN
    want = 32'h55;
`else
    want = 32'h11;
`endif
    n_checks++;
    if (RD1E !== want) begin
      n_fail++; $display("FAIL collision: got %h expected %h", RD1E, want);
    end
    set_in(32'h0003_03B3, 32'h48, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    n_checks++;
    if (RD1E !== 32'h55) begin
      n_fail++; $display("FAIL collision_after: got %h expected 55", RD1E);
    end
  endtask

  task automatic test_illegal();
    set_in(32'h0000_007F, 32'h50, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    n_checks++;
    if (IllegalE !== 1'b1 || RegWriteE !== 1'b0 || MemWriteE !== 1'b0 ||
        dut_ctrl !== 14'h0001) begin
      n_fail++;
      $display("FAIL illegal: got ill=%b rw=%b mw=%b ctrl=%h expected 1/0/0/0001",
               IllegalE, RegWriteE, MemWriteE, dut_ctrl);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [7];
    logic [31:0] ins;
    logic [4:0]  wa;
    logic [13:0] ectl;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h37};
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      if ($urandom_range(7) != 0) begin
        ins[6:0] = ops[$urandom_range(6)];
      end else begin
        while (ins[6:0] inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h37})
          ins[6:0] = 7'($urandom);
      end
      wa = ($urandom_range(3) == 0) ? ins[19:15] : 5'($urandom);
      set_in(ins, $urandom & 32'hFFFF_FFFC, ($urandom_range(9) == 0),
             ($urandom_range(1) == 1), wa, $urandom);
      #1;
      n_checks++;
      if ({Rs1D, Rs2D} !== {ins[19:15], ins[24:20]}) begin
        n_fail++; $display("FAIL rand_rsD: got %h expected %h", {Rs1D, Rs2D},
                           {ins[19:15], ins[24:20]});
      end
      cycle();
      ectl = {exp_e.rw, exp_e.mw, exp_e.j, exp_e.b, exp_e.as, exp_e.rs,
              exp_e.alu, exp_e.f3, exp_e.ill};
      n_checks++;
      if (dut_ctrl !== ectl) begin
        n_fail++; $display("FAIL rand_ctrl ins=%h: got %b expected %b", ins, dut_ctrl, ectl);
      end
      n_checks++;
      if (RD1E !== exp_e.rd1 || RD2E !== exp_e.rd2) begin
        n_fail++; $display("FAIL rand_rd ins=%h: got %h/%h expected %h/%h",
                           ins, RD1E, RD2E, exp_e.rd1, exp_e.rd2);
      end
      n_checks++;
      if (PCE !== exp_e.pc || PCPlus4E !== exp_e.pc4 ||
          dut_idx !== {exp_e.rd, exp_e.rs1, exp_e.rs2}) begin
        n_fail++; $display("FAIL rand_pc_idx ins=%h: got %h/%h/%h expected %h/%h/%h",
                           ins, PCE, PCPlus4E, dut_idx, exp_e.pc, exp_e.pc4,
                           {exp_e.rd, exp_e.rs1, exp_e.rs2});
      end
      if (exp_e.imm_v) begin
        n_checks++;
        if (ImmExtE !== exp_e.imm) begin
          n_fail++; $display("FAIL rand_imm ins=%h: got %h expected %h", ins, ImmExtE, exp_e.imm);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    rst = 1'b1;
    set_in(32'h0000_0013, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_addi();
    test_writeback_read();
    test_branch();
    test_flush();
    test_collision();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Decode stage of the 5-stage RV32I pipeline; consumes InstrD/PCD/PCPlus4D from fetch_cycle.
- Contains the 32x32 register file, main/ALU control decoder and immediate generator.
- Registers all results into the ID/EX pipeline register feeding execute.
- Accepts the writeback port from WB and a flush from the hazard unit.

Parameters:
- XLEN, 32, datapath width
- REG_COUNT, 32, architectural registers; index width 5

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  WB register-write enable
- RdW  in  5  WB destination
- ResultW  in  32  WB data
- FlushE  in  1  hazard unit: bubble ID/EX
- Rs1D, Rs2D  out  5 each  combinational InstrD[19:15]/[24:20] for hazard unit
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control
- ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
- ALUControlE  out  3  ALU op
- Funct3E  out  3  branch/load/store type
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered data
- RdE, Rs1E, Rs2E  out  5 each  registered register indices
- IllegalE  out  1  unsupported opcode in E

Behaviour:
- Decode is combinational on InstrD. All E outputs update on the rising edge; decode-to-E latency is 1 cycle.
- Reset (rst=0 at the edge):
  - every E output goes to 0;
  - all 31 writable registers go to 0.
  - Reset dominates FlushE and writeback.
- FlushE=1 (rst=1): all E outputs go to 0 next edge (NOP bubble).
  - Register file write still occurs that cycle.
- No stall input: ID/EX loads every cycle. The hazard unit stalls via fetch's EN1/EN2 and FlushE.
- Register file:
  - Two combinational read ports.
  - One write port, written on the rising edge when RegWriteW=1 and RdW!=0.
  - x0 always reads 0; writes to x0 are ignored.
- Decoded opcodes (others are illegal):
  - lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111, lui 0110111.
  - Illegal opcode: all control bits 0, IllegalE=1 next cycle.
- ImmSrc and immediate forms, all sign-extended to 32 bits (from bit 31 of InstrD):
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
  - U: {[31:12],12'b0}, no extension needed
- ALUControl encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
  - sub only for R-type with funct7[5]=1 and funct3=000.
  - Branch uses sub.
  - lw/sw/jal/lui use add.
- lui: ResultSrc=11, RegWrite=1.
- jal: JumpE=1, ResultSrc=10, RegWrite=1.
- Same-cycle write and read of the same register without the optional feature: the read returns the old value. The hazard unit must cover this case.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: a read port returns ResultW when RegWriteW=1, RdW!=0 and RdW equals that port's index (write-through).
- Undefined: plain register read; old value returned on collision.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams;
  - ALUControl, ResultSrc and ImmSrc encodings;
  - XLEN and register index width.
- Sub-module register_file: 2R1W, reset, optional bypass.
- Control decode and immediate generation stay inline.

Test Plan:
- Reset: rst=0 for 2 cycles with InstrD=0x00500093 -> all E outputs 0, IllegalE=0; after release, x1..x31 read 0.
- addi x1,x0,5 (0x00500093), PCD=0x10 -> next cycle:
  - RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000, PCE=0x10, PCPlus4E=0x14.
- Writeback then read:
  - RegWriteW=1, RdW=3, ResultW=0xDEADBEEF, then add x4,x3,x0 -> RD1E=0xDEADBEEF.
  - RdW=0 write -> x0 still reads 0.
- beq x1,x2,-8 (0xFE208CE3) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8, Funct3E=000.
- FlushE=1 with sw x2,8(x1) in D -> next cycle all E outputs 0; a concurrent WB write to x5 still lands.
- Same-cycle collision, WB writes x6=0x55 while D reads x6:
  - with WB_BYPASS_EN, RD1E=0x55;
  - without it, RD1E=old value.
- Illegal 0x0000007F -> IllegalE=1, RegWriteE=MemWriteE=0.
